ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard over the same PS2_CLK/PS2_DAT pair that the `keyboard` receiver listens on. Typical uses are 0xED followed by an LED mask, or 0xFF reset. The block runs the full host-request sequence: inhibit, request-to-send, bit shifting on device clock edges, odd parity, stop, and device acknowledge. It drives the open-drain lines through low-enables and tells the receiver to ignore the bus while a transfer is in progress.

---
 rtl/ps2_host_tx.sv | 165 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one odd-parity
// byte out on device clock falls and samples the device ACK on the 11th fall.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned PACKET_TIMEOUT = 100000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] PKT_LAST   = 20'(PACKET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_WAIT_IDLE
  } state_e;

  // Index 0 = clock line, index 1 = data line.
  logic [1:0]          sync1_q, sync2_q, filt_q;
  logic [1:0][FCW-1:0] fcnt_q;
  logic                fall;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= {ps2_dat_in, ps2_clk_in};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FLT_LAST) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FCW'(1);
        end
      end
    end
  end

  // Fires in the cycle the filtered clock is about to switch from high to low.
  assign fall = filt_q[0] & ~sync2_q[0] & (fcnt_q[0] == FLT_LAST);

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  shreg_q, shreg_d;
  logic        ack_q, ack_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ack_q   <= ack_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no path
  // through the state decode can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 20'd1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    ack_d      = ack_q;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          shreg_d = {1'b1, ~^tx_data, tx_data};
          ack_d   = 1'b0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        ps2_dat_oe = 1'b1;
        if (cnt_q == START_LAST) begin
          tx_error = 1'b1;
          state_d  = S_IDLE;
        end else if (fall) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_BITS;
        end
      end
      S_BITS: begin
        ps2_dat_oe = ~shreg_q[0];
        if (cnt_q == PKT_LAST) begin
          tx_error = 1'b1;
          ack_d    = 1'b0;
          state_d  = S_IDLE;
        end else if (fall) begin
          if (bit_q == 4'd9) begin
            // 11th fall: the device holds data low here to acknowledge.
            ack_d   = ~filt_q[1];
            state_d = S_WAIT_IDLE;
          end else begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_WAIT_IDLE: begin
        // The counter keeps running from BITS so one timer covers the whole packet.
        if (cnt_q == PKT_LAST) begin
          tx_error = 1'b1;
          ack_d    = 1'b0;
          state_d  = S_IDLE;
        end else if (filt_q == 2'b11) begin
          tx_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = ~tx_ready;
  assign rx_inhibit = busy;
  assign tx_ack_ok  = ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock and ACK, and the
// observed dat_oe frame is compared against a byte-level model of the host frame.
module tb_ps2_host_tx;

  localparam int INH = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       busy, rx_inhibit, tx_done, tx_ack_ok, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0, err_cnt = 0, run_len = 0, last_run = 0;
  logic done_ack = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT(200), .PACKET_TIMEOUT(2000), .FILTER_LEN(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy), .rx_inhibit(rx_inhibit),
    .tx_done(tx_done), .tx_ack_ok(tx_ack_ok), .tx_error(tx_error)
  );

  always @(negedge CLOCK_50) begin
    if (tx_done) begin
      done_cnt = done_cnt + 1;
      done_ack = tx_ack_ok;
    end
    if (tx_error) err_cnt = err_cnt + 1;
    if (ps2_clk_oe) run_len = run_len + 1;
    else if (run_len > 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected dat_oe before each of the 11 falls: start, ~data LSB first, ~odd parity, stop.
  function automatic logic [10:0] model_oe(input logic [7:0] d);
    logic [10:0] r;
    int ones = 0;
    r[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r[i+1] = !d[i];
      ones   = ones + int'(d[i]);
    end
    r[9]  = !((ones % 2) == 0);
    r[10] = 1'b0;
    return r;
  endfunction

  task automatic handshake(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!tx_ready) check("ready_wait_timeout", 0, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    check("hs_clk_oe", ps2_clk_oe, 1);
    check("hs_busy", {busy, rx_inhibit, tx_ready}, 3'b110);
  endtask

  task automatic device(input bit ack, input bit glitch, input int n_edges,
                        output logic [10:0] seen);
    int n = 0;
    seen = '0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!(ps2_dat_oe && !ps2_clk_oe)) begin
      check("req_wait_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < n_edges; k++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge CLOCK_50);
        if (glitch && k == 4 && c == 1) dev_clk_low = 1'b1;
        if (glitch && k == 4 && c == 3) dev_clk_low = 1'b0;
        if (ack && k == 10 && c == 2) dev_dat_low = 1'b1;
        if (c == 8) seen[k] = ps2_dat_oe;
      end
      dev_clk_low = 1'b1;
      repeat (10) @(negedge CLOCK_50);
      dev_clk_low = 1'b0;
    end
    repeat (4) @(negedge CLOCK_50);
    dev_dat_low = 1'b0;
  endtask

  task automatic finish_frame(input logic [7:0] d, input logic [10:0] seen, input int d0,
                              input int e0, input bit exp_par_oe, input bit exp_ack);
    int n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(negedge CLOCK_50);
      n++;
    end
    repeat (3) @(negedge CLOCK_50);
    check("frame_oe", 32'(seen), 32'(model_oe(d)));
    check("parity_oe", 32'(seen[9]), 32'(exp_par_oe));
    check("done_pulses", done_cnt - d0, 1);
    check("ack_ok", done_ack, exp_ack);
    check("no_error", err_cnt - e0, 0);
    check("inhibit_len", last_run, INH);
    check("ready_after", tx_ready, 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch,
                           input bit exp_par_oe, input bit exp_ack);
    logic [10:0] seen;
    int d0 = done_cnt;
    int e0 = err_cnt;
    handshake(d);
    device(ack, glitch, 11, seen);
    finish_frame(d, seen, d0, e0, exp_par_oe, exp_ack);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         glitch;
    bit         exp_par_oe;
    bit         exp_ack_ok;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [10:0] seen;
    int d0, e0, n;
    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hF4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("reset_ready", {tx_ready, busy, rx_inhibit}, 3'b100);
    check("reset_pulses", {tx_done, tx_ack_ok, tx_error}, 3'b000);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].data, vecs[i].ack, vecs[i].glitch, vecs[i].exp_par_oe, vecs[i].exp_ack_ok);

    // Back-to-back: tx_valid raised in the tx_done cycle must wait one cycle.
    d0 = done_cnt; e0 = err_cnt;
    handshake(8'h07);
    device(1'b1, 1'b0, 11, seen);
    n = 0;
    while (!tx_done && n < 500) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("b2b_done_seen", tx_done, 1);
    check("b2b_not_ready_on_done", tx_ready, 0);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge CLOCK_50);
    check("b2b_ready_next", tx_ready, 1);
    check("b2b_not_accepted", ps2_clk_oe, 0);
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    check("b2b_accepted", {ps2_clk_oe, tx_ready}, 2'b10);
    check("b2b_first_frame", 32'(seen), 32'(model_oe(8'h07)));
    check("b2b_first_parity", 32'(seen[9]), 1);
    check("b2b_first_inhibit", last_run, INH);
    device(1'b1, 1'b0, 11, seen);
    finish_frame(8'h00, seen, d0 + 1, e0, 1'b0, 1'b1);

    // Device never clocks: error in REQ cycle 200.
    d0 = done_cnt; e0 = err_cnt;
    handshake(8'h12);
    n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 500) begin
      @(negedge CLOCK_50);
      n++;
    end
    n = 1;
    while (!tx_error && n < 400) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("start_timeout_cycle", n, 200);
    @(negedge CLOCK_50);
    check("start_to_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("start_to_ready", tx_ready, 1);
    @(negedge CLOCK_50);
    check("start_to_err_cnt", err_cnt - e0, 1);
    check("start_to_no_done", done_cnt - d0, 0);
    check("start_to_ack", tx_ack_ok, 0);

    // Device stops after three falls: packet timer expires.
    d0 = done_cnt; e0 = err_cnt;
    handshake(8'h34);
    device(1'b1, 1'b0, 3, seen);
    n = 0;
    while (err_cnt == e0 && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    @(negedge CLOCK_50);
    check("pkt_to_err_cnt", err_cnt - e0, 1);
    check("pkt_to_no_done", done_cnt - d0, 0);
    check("pkt_to_state", {ps2_clk_oe, ps2_dat_oe, tx_ready, tx_ack_ok}, 4'b0010);

    // Reset during BITS after four data bits.
    d0 = done_cnt; e0 = err_cnt;
    handshake(8'h55);
    device(1'b1, 1'b0, 5, seen);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rst_mid_ready", {tx_ready, busy, rx_inhibit}, 3'b100);
    check("rst_mid_pulses", {tx_done, tx_error}, 2'b00);
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    check("rst_mid_no_events", (done_cnt - d0) + (err_cnt - e0), 0);

    for (int i = 0; i < 6; i++) begin
      logic [7:0]  d;
      logic [10:0] m;
      bit          a;
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      m = model_oe(d);
      run_frame(d, a, 1'b0, m[9], a);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
